// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and width-independent two's-complement helpers (callers truncate the result).
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   // Low bits of the result are the correct negation at any narrower width.
   function automatic logic [63:0] twos_neg(input logic [63:0] x);
      return ~x + 64'd1;
   endfunction

   // Magnitude of a value whose sign is supplied separately by the caller.
   function automatic logic [63:0] abs_val(input logic [63:0] x, input logic neg);
      return neg ? twos_neg(x) : x;
   endfunction

endpackage

// File: rtl/hilo_if.sv
// Issue/result bundle between the execute stage and the HI/LO unit.
interface hilo_if #(parameter int WIDTH = 32) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit_div_iter.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Produces a one-cycle valid pulse after WIDTH iterations; cancel aborts.
module hilo_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last,
   output logic             valid
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             active_q, active_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             valid_q, valid_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             ge;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      shifted  = {rem_q, quo_q[WIDTH-1]};
      diff     = shifted - {1'b0, dvs_q};
      ge       = (shifted >= {1'b0, dvs_q});
      active_d = active_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      valid_d  = 1'b0;
      if (cancel) begin
         active_d = 1'b0;
      end else if (start) begin
         active_d = 1'b1;
         cnt_d    = CW'(WIDTH - 1);
         rem_d    = '0;
         quo_d    = dividend;
         dvs_d    = divisor;
      end else if (active_q) begin
         rem_d = ge ? WIDTH'(diff) : WIDTH'(shifted);
         quo_d = {quo_q[WIDTH-2:0], ge};
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) begin
            active_d = 1'b0;
            valid_d  = 1'b1;
         end
      end
   end

   // Divider state registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         valid_q  <= valid_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign last      = active_q && (cnt_q == '0);
   assign valid     = valid_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the execute stage: pipelined multiply, iterative divide
// with sign fix-up, and MTHI/MTLO. busy feeds the hazard unit's stall.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3
) (
   input logic   clk,
   input logic   rst,
   hilo_if.slave bus
);

   localparam int PW = 2 * WIDTH;

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
   logic                    done_q, done_d;
   logic [WIDTH-1:0]        a_q, a_d;
   logic                    dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;
   logic signed [PW-1:0]    prod_q [MUL_LAT];
   logic signed [PW-1:0]    prod_d [MUL_LAT];
   logic [MUL_LAT-1:0]      vld_q, vld_d;

   logic                    accept, is_mul, is_div, mul_signed, mul_wr;
   logic                    a_neg, b_neg;
   logic signed [PW-1:0]    mul_a, mul_b, mul_prod;
   logic [WIDTH-1:0]        dvd_mag, dvs_mag, div_quo, div_rem, quo_fix, rem_fix;
   logic                    div_last, div_vld;

   assign accept     = bus.start && (state_q == ST_IDLE) && !bus.cancel;
   assign is_mul     = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
   assign is_div     = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign mul_signed = (bus.op == OP_MULT);
   assign a_neg      = (bus.op == OP_DIV) && bus.a[WIDTH-1];
   assign b_neg      = (bus.op == OP_DIV) && bus.b[WIDTH-1];
   assign dvd_mag    = WIDTH'(abs_val(64'(bus.a), a_neg));
   assign dvs_mag    = WIDTH'(abs_val(64'(bus.b), b_neg));
   assign quo_fix    = qneg_q ? WIDTH'(twos_neg(64'(div_quo))) : div_quo;
   assign rem_fix    = rneg_q ? WIDTH'(twos_neg(64'(div_rem))) : div_rem;
   assign mul_wr     = vld_q[MUL_LAT-1] && (state_q == ST_MUL) && !bus.cancel;

   hilo_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (accept && is_div),
      .cancel    (bus.cancel),
      .dividend  (dvd_mag),
      .divisor   (dvs_mag),
      .quotient  (div_quo),
      .remainder (div_rem),
      .last      (div_last),
      .valid     (div_vld)
   );

   // Full-width product, then retimed through MUL_LAT stages; cancel drops it.
   always_comb begin
      mul_a     = {{WIDTH{mul_signed && bus.a[WIDTH-1]}}, bus.a};
      mul_b     = {{WIDTH{mul_signed && bus.b[WIDTH-1]}}, bus.b};
      mul_prod  = mul_a * mul_b;
      prod_d[0] = mul_prod;
      vld_d     = '0;
      for (int i = 1; i < MUL_LAT; i++) prod_d[i] = prod_q[i-1];
      if (!bus.cancel) begin
         vld_d[0] = accept && is_mul;
         for (int i = 1; i < MUL_LAT; i++) vld_d[i] = vld_q[i-1];
      end
   end

   // Control FSM and HI/LO write selection; cancel discards any same-edge write.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      a_d     = a_q;
      dz_d    = dz_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  state_d = ST_MUL;
               end else if (is_div) begin
                  state_d = ST_DIV;
                  a_d     = bus.a;
                  dz_d    = (bus.b == '0);
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
               end else if (bus.op == OP_MTHI) begin
                  hi_d   = bus.a;
                  done_d = 1'b1;
               end else if (bus.op == OP_MTLO) begin
                  lo_d   = bus.a;
                  done_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (bus.cancel) begin
               state_d = ST_IDLE;
            end else if (mul_wr) begin
               {hi_d, lo_d} = prod_q[MUL_LAT-1];
               done_d       = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         ST_DIV: begin
            if (bus.cancel) state_d = ST_IDLE;
            else if (div_last) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!bus.cancel && div_vld) begin
               done_d = 1'b1;
               if (dz_q) begin
                  lo_d = '1;
                  hi_d = a_q;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, architectural HI/LO and multiply pipeline registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         a_q     <= '0;
         dz_q    <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         vld_q   <= '0;
         for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         a_q     <= a_d;
         dz_q    <= dz_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         vld_q   <= vld_d;
         for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= prod_d[i];
      end
   end

   assign bus.busy = (state_q != ST_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit (WIDTH=32, MUL_LAT=3).
module tb_hilo_muldiv_unit;
   import hilo_pkg::*;

   localparam int W   = 32;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hilo_if #(.WIDTH(W)) bus ();

   hilo_muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [2*W-1:0] sb_q [$];

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      logic [W-1:0] ehi;
      logic [W-1:0] elo;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Issue one op, measure busy length, then compare HI/LO with the scoreboard.
   task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input int lat,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int n;
      logic [2*W-1:0] exp;
      sb_q.push_back({ehi, elo});
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.a = ia; bus.b = ib;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk({nm, "_busy_len"}, 64'(n), 64'(lat));
      chk({nm, "_done"}, 64'(bus.done), 64'd1);
      exp = sb_q.pop_front();
      chk({nm, "_hi"}, 64'(bus.hi), 64'(exp[2*W-1:W]));
      chk({nm, "_lo"}, 64'(bus.lo), 64'(exp[W-1:0]));
      @(negedge clk);
      chk({nm, "_done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   // Issue one op and cancel it in busy cycle k; HI/LO must stay at ehi/elo.
   task automatic cancel_at(input string nm, input logic [2:0] o, input logic [W-1:0] ia,
                            input logic [W-1:0] ib, input int k,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int   n;
      logic seen;
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.a = ia; bus.b = ib;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         n++;
         if (n == k) bus.cancel = 1'b1;
         @(negedge clk);
      end
      bus.cancel = 1'b0;
      chk({nm, "_busy_len"}, 64'(n), 64'(k));
      chk({nm, "_done"}, 64'(bus.done), 64'd0);
      chk({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
      chk({nm, "_lo"}, 64'(bus.lo), 64'(elo));
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | bus.done | bus.busy;
      end
      chk({nm, "_quiet"}, 64'(seen), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic [W-1:0] ia, ib;
      logic [63:0]  p;

      vt[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, LAT,   32'hFFFFFFFF, 32'hFFFFFFF1};
      vt[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT,   32'hFFFFFFFE, 32'h00000001};
      vt[2]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, LAT,   32'h3FFFFFFF, 32'h00000001};
      vt[3]  = '{OP_MULT,  32'h80000000, 32'h00000001, LAT,   32'hFFFFFFFF, 32'h80000000};
      vt[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, W + 1, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vt[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, W + 1, 32'h00000000, 32'h80000000};
      vt[6]  = '{OP_DIVU,  32'h00001234, 32'h00000000, W + 1, 32'h00001234, 32'hFFFFFFFF};
      vt[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, W + 1, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vt[8]  = '{OP_DIVU,  32'd100,      32'd7,        W + 1, 32'd2,        32'd14};
      vt[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, W + 1, 32'h00000001, 32'hFFFFFFFD};
      vt[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       W + 1, 32'd5,        32'h19999999};
      vt[11] = '{OP_MTHI,  32'h0000AAAA, 32'h0,        0,     32'h0000AAAA, 32'h19999999};
      vt[12] = '{OP_MTLO,  32'h00005555, 32'h0,        0,     32'h0000AAAA, 32'h00005555};

      rst = 1'b0;
      bus.start = 1'b0; bus.cancel = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi",   64'(bus.hi),   64'd0);
      chk("rst_lo",   64'(bus.lo),   64'd0);
      rst = 1'b1;

      for (int i = 0; i < 13; i++)
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].lat, vt[i].ehi, vt[i].elo);

      // Cancels: mid-divide, mid-multiply, on the multiply write edge, in FIX.
      cancel_at("cxl_div10", OP_DIV,   32'd100, 32'd7, 10,    32'h0000AAAA, 32'h00005555);
      cancel_at("cxl_mul1",  OP_MULT,  32'd3,   32'd4, 1,     32'h0000AAAA, 32'h00005555);
      cancel_at("cxl_mulwr", OP_MULTU, 32'd3,   32'd4, LAT,   32'h0000AAAA, 32'h00005555);
      cancel_at("cxl_fix",   OP_DIVU,  32'd100, 32'd7, W + 1, 32'h0000AAAA, 32'h00005555);

      // start together with cancel is not accepted.
      @(negedge clk);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MTHI; bus.a = 32'h1111;
      @(posedge clk);
      #1 begin bus.start = 1'b0; bus.cancel = 1'b0; end
      @(negedge clk);
      chk("sc_mthi_busy", 64'(bus.busy), 64'd0);
      chk("sc_mthi_done", 64'(bus.done), 64'd0);
      chk("sc_mthi_hi",   64'(bus.hi),   64'h0000AAAA);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_DIV; bus.a = 32'd9; bus.b = 32'd2;
      @(posedge clk);
      #1 begin bus.start = 1'b0; bus.cancel = 1'b0; end
      @(negedge clk);
      chk("sc_div_busy", 64'(bus.busy), 64'd0);

      // Starts while busy are ignored.
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         n++;
         if (n == 3) begin bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'hDEAD; end
         if (n == 4) bus.start = 1'b0;
         if (n == 6) begin bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd3; end
         if (n == 7) bus.start = 1'b0;
         @(negedge clk);
      end
      chk("ign_busy_len", 64'(n), 64'(W + 1));
      chk("ign_done",     64'(bus.done), 64'd1);
      chk("ign_hi",       64'(bus.hi),   64'd2);
      chk("ign_lo",       64'(bus.lo),   64'd14);
      @(negedge clk);
      chk("ign_no_extra", 64'(bus.busy | bus.done), 64'd0);

      // Random unsigned operations against a plain arithmetic model.
      for (int i = 0; i < 6; i++) begin
         ia = $urandom;
         ib = $urandom;
         if (i % 2 == 0) begin
            p = {32'd0, ia} * {32'd0, ib};
            run_op("rnd_multu", OP_MULTU, ia, ib, LAT, p[63:32], p[31:0]);
         end else begin
            ib = (ib % 32'd5000) + 32'd1;
            run_op("rnd_divu", OP_DIVU, ia, ib, W + 1, ia % ib, ia / ib);
         end
      end

      // Reset in the middle of a divide.
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         n++;
         if (n == 5) rst = 1'b0;
         @(negedge clk);
      end
      chk("mrst_busy_len", 64'(n),        64'd5);
      chk("mrst_hi",       64'(bus.hi),   64'd0);
      chk("mrst_lo",       64'(bus.lo),   64'd0);
      chk("mrst_done",     64'(bus.done), 64'd0);
      rst = 1'b1;
      run_op("post_rst", OP_MULTU, 32'd6, 32'd7, LAT, 32'd0, 32'd42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core; replaces the fixed single-cycle hilo register path.
- Sits beside the execute-stage ALU and owns the architectural HI and LO registers.
- Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiplies complete after a configurable latency; divides are iterative; a busy output drives the hazard unit's stall.

Parameters:
- WIDTH, 32: operand width and HI/LO width, even, 8..64.
- MUL_LAT, 3: multiply latency in cycles from accept to HI/LO update, 1..8; product is retimed through a pipeline of MUL_LAT registers.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a new operation this cycle.
- op  in  3  operation code from the package: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
- a  in  WIDTH  rs operand; dividend, multiplicand, or MTHI/MTLO source.
- b  in  WIDTH  rt operand; divisor or multiplier.
- cancel  in  1  flush from the hazard unit; aborts the in-flight operation.
- busy  out  1  unit occupied (state != IDLE).
- done  out  1  one-cycle pulse in the first cycle in which the new HI/LO values are visible.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter and pipeline cleared. Reset wins over all other inputs, including mid-operation.
- Accept rule: an operation is accepted when start=1, busy=0 and cancel=0.
  - start while busy is ignored; there is no queue, and the issuer stalls on busy.
  - start together with cancel is not accepted.
- States: IDLE, MUL, DIV, FIX.
- MTHI/MTLO:
  - Written at the accept edge; busy stays 0.
  - done=1 in the following cycle.
  - The other register is unchanged.
- MULT/MULTU:
  - IDLE->MUL at the accept edge.
  - Full 2*WIDTH product computed: signed for MULT, unsigned for MULTU.
  - {hi,lo} is written at edge MUL_LAT after accept, and the state returns to IDLE at that edge.
  - busy=1 for exactly MUL_LAT cycles; done=1 in the cycle after the write.
- DIV/DIVU:
  - IDLE->DIV at the accept edge; operand magnitudes latched (absolute values for DIV).
  - Restoring division, 1 quotient bit per cycle, WIDTH cycles; counter runs WIDTH-1 down to 0, then DIV->FIX.
  - FIX, 1 cycle: sign correction. Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder written at the FIX->IDLE edge.
  - Total busy = WIDTH+1 cycles; done follows the write.
- Divide by zero: same latency, lo=all-ones, hi=a (dividend unchanged). Identical for DIV and DIVU.
- Signed overflow (DIV, a=most-negative, b=-1): lo=most-negative, hi=0.
- cancel while busy:
  - Next edge -> IDLE; busy=0 the following cycle.
  - hi/lo keep their pre-operation values; no done pulse.
- cancel while idle: no effect.
- A write lands on the same edge as cancel: cancel wins and the write is discarded.
- hi/lo outputs are registers; no combinational path from inputs to hi/lo/busy/done.

Decomposition:
- Shared package hilo_pkg holds:
  - op encodings (3-bit localparams);
  - state encoding;
  - WIDTH-independent helper functions: two's-complement negate, absolute value.
- One sub-module: hilo_div_iter, the iterative restoring divider.
  - Inputs: start/cancel, unsigned magnitudes.
  - Outputs: quotient/remainder magnitudes plus a valid pulse after WIDTH cycles.
- Sign fix-up, the multiply pipeline and HI/LO ownership stay in the top module.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, MUL_LAT=3 -> busy high 3 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse 1 cycle.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> busy 33 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00001234.
- Preload MTHI 0xAAAA, MTLO 0x5555; start DIV, assert cancel at busy cycle 10 -> busy low next cycle, no done, hi=0xAAAA and lo=0x5555 retained. Also issue start+cancel together -> not accepted.
- Assert rst=0 at busy cycle 5 of DIVU -> next cycle hi=lo=0, busy=0, done=0. A start during busy is ignored and HI/LO reflect only the first operation.
